// File: rtl/nubus_pkg.sv
// Shared definitions for the NuBus slave: FSM state encoding, acknowledge
// status codes and the standard slot-space nibble.
package nubus_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [1:0] ST_COMPLETE = 2'b00;
  localparam logic [1:0] ST_ERROR    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT  = 2'b10;
  localparam logic [1:0] ST_TRYAGAIN = 2'b11;

  // Standard slot space lives at 0xFs00_0000..0xFsFF_FFFF for slot s.
  localparam logic [3:0] SLOT_SPACE = 4'hF;

endpackage

// File: rtl/nubus_slot_decode.sv
// Combinational slot decode on the true (non-inverted) address byte.
// Super-slot decode exists only when NUBUS_SLAVE_SUPERSLOT_EN is defined.
module nubus_slot_decode
  import nubus_pkg::*;
(
  input  logic [7:0] addr_hi,
  input  logic [3:0] slot_id,
  output logic       std_hit
`ifdef NUBUS_SLAVE_SUPERSLOT_EN
  ,
  output logic       super_hit
`endif
);

  assign std_hit = (addr_hi == {SLOT_SPACE, slot_id});

`ifdef NUBUS_SLAVE_SUPERSLOT_EN
  // Slot 0 has no super-slot space.
  assign super_hit = (addr_hi[7:4] == slot_id) && (slot_id != 4'h0);
`endif

endmodule

// File: rtl/nubus_slave_fsm.sv
// NuBus slave transaction FSM: claims slot-space starts, runs the local
// access with timeout/retry, then issues a single-cycle acknowledge.
// Optional super-slot decode: define NUBUS_SLAVE_SUPERSLOT_EN.
module nubus_slave_fsm
  import nubus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC  = 255,
  parameter int unsigned CNT_W        = 8,
  parameter bit          RETRY_EN_DEF = 1'b1
) (
  input  logic        nub_clkn,
  input  logic        nub_resetn,
  input  logic        nub_startn,
  input  logic        nub_ackn,
  input  logic        nub_tm1n,
  input  logic        nub_tm0n,
  input  logic [31:0] nub_adn,
  input  logic [3:0]  slot_id,
  input  logic        mem_ready,
  input  logic        mem_error,
  input  logic        mem_busy,
  output logic        slave_o,
  output logic        mem_req_o,
  output logic [31:0] addr_o,
  output logic [1:0]  tm_o,
  output logic        ack_o,
  output logic [1:0]  status_o,
  output logic        superslot_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt;
  logic             retry_en;
  logic [1:0]       status_d;
  logic             take;
  logic             hit;
  logic             std_hit;
  logic             start;
  logic             ack_in;
  logic [31:0]      addr_true;

  assign start     = ~nub_startn;
  assign ack_in    = ~nub_ackn;
  assign addr_true = ~nub_adn;

`ifdef NUBUS_SLAVE_SUPERSLOT_EN
  logic super_hit;

  nubus_slot_decode u_decode (
    .addr_hi   (addr_true[31:24]),
    .slot_id   (slot_id),
    .std_hit   (std_hit),
    .super_hit (super_hit)
  );

  assign hit = std_hit | super_hit;

  always_ff @(posedge nub_clkn) begin
    if (!nub_resetn) begin
      superslot_o <= 1'b0;
    end else if (take) begin
      superslot_o <= super_hit & ~std_hit;
    end
  end
`else
  nubus_slot_decode u_decode (
    .addr_hi (addr_true[31:24]),
    .slot_id (slot_id),
    .std_hit (std_hit)
  );

  assign hit         = std_hit;
  assign superslot_o = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state;
    status_d = status_o;
    take     = 1'b0;
    unique case (state)
      S_IDLE: begin
        // A start during an attention cycle (ACK also low) is not a transaction.
        if (start && !ack_in && hit) begin
          take    = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        state_d = S_ACK;
        if (mem_error)                  status_d = ST_ERROR;
        else if (mem_ready)             status_d = ST_COMPLETE;
        else if (mem_busy && retry_en)  status_d = ST_TRYAGAIN;
        else if (cnt == CNT_LAST)       status_d = ST_TIMEOUT;
        else                            state_d  = S_WAIT;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments so all update on the same edge.
  always_ff @(posedge nub_clkn) begin
    if (!nub_resetn) state <= S_IDLE;
    else             state <= state_d;
  end

  always_ff @(posedge nub_clkn) begin
    if (!nub_resetn) begin
      cnt      <= '0;
      addr_o   <= '0;
      tm_o     <= 2'b00;
      status_o <= ST_COMPLETE;
      retry_en <= RETRY_EN_DEF;
    end else begin
      status_o <= status_d;
      if (take) begin
        addr_o <= addr_true;
        tm_o   <= ~{nub_tm1n, nub_tm0n};
      end
      if (state == S_WAIT) cnt <= cnt + CNT_ONE;
      else                 cnt <= '0;
    end
  end

  assign slave_o   = (state != S_IDLE);
  assign mem_req_o = (state == S_WAIT);
  assign ack_o     = (state == S_ACK);

endmodule

// File: tb/tb_nubus_slave_fsm.sv
// Directed bench for nubus_slave_fsm (TIMEOUT_CYC=4); super-slot checks
// follow NUBUS_SLAVE_SUPERSLOT_EN.
module tb_nubus_slave_fsm;

  logic        nub_clkn = 1'b0;
  logic        nub_resetn;
  logic        nub_startn, nub_ackn, nub_tm1n, nub_tm0n;
  logic [31:0] nub_adn;
  logic [3:0]  slot_id;
  logic        mem_ready, mem_error, mem_busy;
  logic        slave_o, mem_req_o, ack_o, superslot_o;
  logic [31:0] addr_o;
  logic [1:0]  tm_o, status_o;

  int n_run  = 0;
  int n_fail = 0;

  nubus_slave_fsm #(
    .TIMEOUT_CYC  (4),
    .CNT_W        (8),
    .RETRY_EN_DEF (1'b1)
  ) dut (
    .nub_clkn    (nub_clkn),
    .nub_resetn  (nub_resetn),
    .nub_startn  (nub_startn),
    .nub_ackn    (nub_ackn),
    .nub_tm1n    (nub_tm1n),
    .nub_tm0n    (nub_tm0n),
    .nub_adn     (nub_adn),
    .slot_id     (slot_id),
    .mem_ready   (mem_ready),
    .mem_error   (mem_error),
    .mem_busy    (mem_busy),
    .slave_o     (slave_o),
    .mem_req_o   (mem_req_o),
    .addr_o      (addr_o),
    .tm_o        (tm_o),
    .ack_o       (ack_o),
    .status_o    (status_o),
    .superslot_o (superslot_o)
  );

  always #5 nub_clkn = ~nub_clkn;

  task automatic bus_idle();
    nub_startn = 1'b1;
    nub_ackn   = 1'b1;
    nub_tm1n   = 1'b1;
    nub_tm0n   = 1'b1;
    nub_adn    = 32'hFFFF_FFFF;
    mem_ready  = 1'b0;
    mem_error  = 1'b0;
    mem_busy   = 1'b0;
  endtask

  // Present a start for one cycle at the next falling edge (true values in).
  task automatic drive_start(input logic [31:0] addr, input logic [1:0] tm, input logic ackn);
    @(negedge nub_clkn);
    nub_startn = 1'b0;
    nub_ackn   = ackn;
    nub_adn    = ~addr;
    {nub_tm1n, nub_tm0n} = ~tm;
  endtask

  task automatic test_reset();
    bus_idle();
    slot_id    = 4'h9;
    nub_resetn = 1'b0;
    repeat (2) @(negedge nub_clkn);
    n_run++; if (slave_o !== 1'b0)     begin n_fail++; $display("FAIL rst_slave: got %b want 0", slave_o); end
    n_run++; if (mem_req_o !== 1'b0)   begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", mem_req_o); end
    n_run++; if (ack_o !== 1'b0)       begin n_fail++; $display("FAIL rst_ack: got %b want 0", ack_o); end
    n_run++; if (status_o !== 2'b00)   begin n_fail++; $display("FAIL rst_status: got %b want 00", status_o); end
    n_run++; if (addr_o !== 32'h0)     begin n_fail++; $display("FAIL rst_addr: got %h want 0", addr_o); end
    n_run++; if (tm_o !== 2'b00)       begin n_fail++; $display("FAIL rst_tm: got %b want 00", tm_o); end
    n_run++; if (superslot_o !== 1'b0) begin n_fail++; $display("FAIL rst_superslot: got %b want 0", superslot_o); end
    nub_resetn = 1'b1;
  endtask

  task automatic test_ready_read();
    drive_start(32'hF900_1000, 2'b10, 1'b1);
    @(negedge nub_clkn);
    bus_idle();
    nub_adn   = ~32'h1234_5678;
    mem_ready = 1'b1;
    n_run++; if (slave_o !== 1'b1)           begin n_fail++; $display("FAIL rd_slave: got %b want 1", slave_o); end
    n_run++; if (mem_req_o !== 1'b1)         begin n_fail++; $display("FAIL rd_mem_req: got %b want 1", mem_req_o); end
    n_run++; if (ack_o !== 1'b0)             begin n_fail++; $display("FAIL rd_early_ack: got %b want 0", ack_o); end
    n_run++; if (addr_o !== 32'hF900_1000)   begin n_fail++; $display("FAIL rd_addr: got %h want f9001000", addr_o); end
    n_run++; if (tm_o !== 2'b10)             begin n_fail++; $display("FAIL rd_tm: got %b want 10", tm_o); end
    n_run++; if (superslot_o !== 1'b0)       begin n_fail++; $display("FAIL rd_superslot: got %b want 0", superslot_o); end
    @(negedge nub_clkn);
    mem_ready = 1'b0;
    n_run++; if (ack_o !== 1'b1)             begin n_fail++; $display("FAIL rd_ack: got %b want 1", ack_o); end
    n_run++; if (status_o !== 2'b00)         begin n_fail++; $display("FAIL rd_status: got %b want 00", status_o); end
    n_run++; if (mem_req_o !== 1'b0)         begin n_fail++; $display("FAIL rd_mem_req_ack: got %b want 0", mem_req_o); end
    n_run++; if (addr_o !== 32'hF900_1000)   begin n_fail++; $display("FAIL rd_addr_hold: got %h want f9001000", addr_o); end
    @(negedge nub_clkn);
    n_run++; if (ack_o !== 1'b0)             begin n_fail++; $display("FAIL rd_ack_end: got %b want 0", ack_o); end
    n_run++; if (slave_o !== 1'b0)           begin n_fail++; $display("FAIL rd_slave_end: got %b want 0", slave_o); end
  endtask

  // Scan a fixed window after a start; returns cycle of first ack and pulse count.
  task automatic test_timeout();
    int ack_cyc = 0, pulses = 0, req_cyc = 0;
    logic [1:0] ack_status = 2'bxx;
    logic       ack_mreq   = 1'bx;
    drive_start(32'hF900_1000, 2'b10, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge nub_clkn);
      if (ack_o === 1'b1) begin
        pulses++;
        if (ack_cyc == 0) begin ack_cyc = c; ack_status = status_o; ack_mreq = mem_req_o; end
      end
      if (mem_req_o === 1'b1) req_cyc++;
      if (c == 1) nub_adn = ~32'hF9AB_CDEF;  // start stays low: a second start during WAIT
      if (c == 2) bus_idle();
    end
    n_run++; if (ack_cyc != 5)              begin n_fail++; $display("FAIL to_ack_cycle: got %0d want 5", ack_cyc); end
    n_run++; if (ack_status !== 2'b10)      begin n_fail++; $display("FAIL to_status: got %b want 10", ack_status); end
    n_run++; if (ack_mreq !== 1'b0)         begin n_fail++; $display("FAIL to_mem_req_ack: got %b want 0", ack_mreq); end
    n_run++; if (pulses != 1)               begin n_fail++; $display("FAIL to_pulses: got %0d want 1", pulses); end
    n_run++; if (req_cyc != 4)              begin n_fail++; $display("FAIL to_wait_cycles: got %0d want 4", req_cyc); end
    n_run++; if (addr_o !== 32'hF900_1000)  begin n_fail++; $display("FAIL to_no_relatch: got %h want f9001000", addr_o); end
    n_run++; if (status_o !== 2'b10)        begin n_fail++; $display("FAIL to_status_hold: got %b want 10", status_o); end
  endtask

  task automatic test_error_ready();
    int ack_cyc = 0, pulses = 0;
    logic [1:0] ack_status = 2'bxx;
    drive_start(32'hF900_2000, 2'b00, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge nub_clkn);
      if (ack_o === 1'b1) begin
        pulses++;
        if (ack_cyc == 0) begin ack_cyc = c; ack_status = status_o; end
      end
      if (c == 1) begin bus_idle(); mem_ready = 1'b1; mem_error = 1'b1; end
    end
    bus_idle();
    n_run++; if (ack_status !== 2'b01) begin n_fail++; $display("FAIL err_status: got %b want 01", ack_status); end
    n_run++; if (pulses != 1)          begin n_fail++; $display("FAIL err_pulses: got %0d want 1", pulses); end
    n_run++; if (ack_cyc != 2)         begin n_fail++; $display("FAIL err_ack_cycle: got %0d want 2", ack_cyc); end
  endtask

  task automatic test_retry();
    int ack_cyc = 0;
    logic [1:0] ack_status = 2'bxx;
    drive_start(32'hF900_5678, 2'b01, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge nub_clkn);
      if (ack_o === 1'b1 && ack_cyc == 0) begin ack_cyc = c; ack_status = status_o; end
      if (c == 1) begin bus_idle(); mem_busy = 1'b1; end
    end
    bus_idle();
    n_run++; if (ack_status !== 2'b11)     begin n_fail++; $display("FAIL retry_status: got %b want 11", ack_status); end
    n_run++; if (ack_cyc != 2)             begin n_fail++; $display("FAIL retry_ack_cycle: got %0d want 2", ack_cyc); end
    n_run++; if (tm_o !== 2'b01)           begin n_fail++; $display("FAIL retry_tm: got %b want 01", tm_o); end
    n_run++; if (addr_o !== 32'hF900_5678) begin n_fail++; $display("FAIL retry_addr: got %h want f9005678", addr_o); end
  endtask

  task automatic test_no_hit();
    drive_start(32'hFA00_0000, 2'b10, 1'b1);
    @(negedge nub_clkn);
    bus_idle();
    n_run++; if (slave_o !== 1'b0)         begin n_fail++; $display("FAIL miss_slave: got %b want 0", slave_o); end
    n_run++; if (mem_req_o !== 1'b0)       begin n_fail++; $display("FAIL miss_mem_req: got %b want 0", mem_req_o); end
    n_run++; if (addr_o !== 32'hF900_5678) begin n_fail++; $display("FAIL miss_addr: got %h want f9005678", addr_o); end
    drive_start(32'hF900_0000, 2'b10, 1'b0);
    @(negedge nub_clkn);
    bus_idle();
    n_run++; if (slave_o !== 1'b0)         begin n_fail++; $display("FAIL attn_slave: got %b want 0", slave_o); end
    n_run++; if (mem_req_o !== 1'b0)       begin n_fail++; $display("FAIL attn_mem_req: got %b want 0", mem_req_o); end
    n_run++; if (tm_o !== 2'b01)           begin n_fail++; $display("FAIL attn_tm: got %b want 01", tm_o); end
  endtask

  task automatic test_reset_in_wait();
    int pulses = 0;
    drive_start(32'hF900_3000, 2'b10, 1'b1);
    @(negedge nub_clkn);
    bus_idle();
    n_run++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL rw_in_wait: got %b want 1", mem_req_o); end
    nub_resetn = 1'b0;
    mem_ready  = 1'b1;
    @(negedge nub_clkn);
    n_run++; if (slave_o !== 1'b0)   begin n_fail++; $display("FAIL rw_slave: got %b want 0", slave_o); end
    n_run++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rw_mem_req: got %b want 0", mem_req_o); end
    n_run++; if (ack_o !== 1'b0)     begin n_fail++; $display("FAIL rw_ack: got %b want 0", ack_o); end
    n_run++; if (status_o !== 2'b00) begin n_fail++; $display("FAIL rw_status: got %b want 00", status_o); end
    n_run++; if (addr_o !== 32'h0)   begin n_fail++; $display("FAIL rw_addr: got %h want 0", addr_o); end
    n_run++; if (tm_o !== 2'b00)     begin n_fail++; $display("FAIL rw_tm: got %b want 00", tm_o); end
    nub_resetn = 1'b1;
    bus_idle();
    for (int c = 0; c < 4; c++) begin
      @(negedge nub_clkn);
      if (ack_o === 1'b1) pulses++;
    end
    n_run++; if (pulses != 0)        begin n_fail++; $display("FAIL rw_no_ack: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_superslot();
    drive_start(32'h9000_0000, 2'b10, 1'b1);
    @(negedge nub_clkn);
    bus_idle();
`ifdef NUBUS_SLAVE_SUPERSLOT_EN
    mem_ready = 1'b1;
    n_run++; if (slave_o !== 1'b1)         begin n_fail++; $display("FAIL ss_slave: got %b want 1", slave_o); end
    n_run++; if (superslot_o !== 1'b1)     begin n_fail++; $display("FAIL ss_flag: got %b want 1", superslot_o); end
    n_run++; if (addr_o !== 32'h9000_0000) begin n_fail++; $display("FAIL ss_addr: got %h want 90000000", addr_o); end
    @(negedge nub_clkn);
    mem_ready = 1'b0;
    n_run++; if (ack_o !== 1'b1)           begin n_fail++; $display("FAIL ss_ack: got %b want 1", ack_o); end
    @(negedge nub_clkn);
`else
    n_run++; if (slave_o !== 1'b0)         begin n_fail++; $display("FAIL ss_slave: got %b want 0", slave_o); end
    n_run++; if (mem_req_o !== 1'b0)       begin n_fail++; $display("FAIL ss_mem_req: got %b want 0", mem_req_o); end
    n_run++; if (superslot_o !== 1'b0)     begin n_fail++; $display("FAIL ss_flag: got %b want 0", superslot_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_ready_read();
    test_timeout();
    test_error_ready();
    test_retry();
    test_no_hit();
    test_reset_in_wait();
    test_superslot();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
